pong_engine: RTL

//  Parametrised two-player Pong game engine. Owns ball position and velocity,

---
 rtl/pong_if.sv | 31 +++
 rtl/pong_engine.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_if.sv
// Game-engine I/O bundle: player controls and frame strobe in, game state out.
// The engine uses the slave view; whatever drives controls and consumes the
// state (VGA renderer, input front end, testbench) uses the master view.
interface pong_if #(
    parameter int W = 10
);
    logic         tick;
    logic         start;
    logic         l_up;
    logic         l_dn;
    logic         r_up;
    logic         r_dn;
    logic [W-1:0] ball_x;
    logic [W-1:0] ball_y;
    logic [W-1:0] l_pos;
    logic [W-1:0] r_pos;
    logic [3:0]   score_l;
    logic [3:0]   score_r;
    logic [1:0]   level;
    logic         game_over;

    modport master (
        output tick, start, l_up, l_dn, r_up, r_dn,
        input  ball_x, ball_y, l_pos, r_pos, score_l, score_r, level, game_over
    );

    modport slave (
        input  tick, start, l_up, l_dn, r_up, r_dn,
        output ball_x, ball_y, l_pos, r_pos, score_l, score_r, level, game_over
    );
endinterface

// File: rtl/pong_engine.sv
// Two-player Pong engine. Owns ball, paddles, scores, speed level and match
// state; advances once per frame strobe (tick) on dclk. Speed levels are a
// per-tick step size rather than separate clocks. All outputs are registered.
module pong_engine #(
    parameter int W           = 10,
    parameter int X_MIN       = 204,
    parameter int X_MAX       = 729,
    parameter int Y_MIN       = 86,
    parameter int Y_MAX       = 456,
    parameter int PAD_LX      = 219,
    parameter int PAD_RX      = 714,
    parameter int PAD_H       = 100,
    parameter int PAD_STEP    = 2,
    parameter int WIN_SCORE   = 9,
    parameter int LEVEL_PTS   = 3,
    parameter int SERVE_TICKS = 60
) (
    input  logic  dclk,
    input  logic  clr,
    pong_if.slave bus
);

    // Two guard bits so coordinate +/- step never wraps before clamping.
    localparam int SW = W + 2;
    localparam int CW = $clog2(SERVE_TICKS + 1);

    localparam int XC       = (X_MIN + X_MAX) / 2;
    localparam int YC       = (Y_MIN + Y_MAX) / 2;
    localparam int PAD_INIT = YC - PAD_H / 2;
    localparam int PAD_MAXT = Y_MAX - PAD_H;

    localparam logic [W-1:0] XC_W       = W'(XC);
    localparam logic [W-1:0] YC_W       = W'(YC);
    localparam logic [W-1:0] PAD_INIT_W = W'(PAD_INIT);
    localparam logic [W-1:0] Y_MIN_W    = W'(Y_MIN);
    localparam logic [W-1:0] Y_MAX_W    = W'(Y_MAX);
    localparam logic [W-1:0] PAD_LX_W   = W'(PAD_LX);
    localparam logic [W-1:0] PAD_RX_W   = W'(PAD_RX);

    localparam logic signed [SW-1:0] ONE_S    = SW'(1);
    localparam logic signed [SW-1:0] XMIN_S   = SW'(X_MIN);
    localparam logic signed [SW-1:0] XMAX_S   = SW'(X_MAX);
    localparam logic signed [SW-1:0] YMIN_S   = SW'(Y_MIN);
    localparam logic signed [SW-1:0] YMAX_S   = SW'(Y_MAX);
    localparam logic signed [SW-1:0] PADLX_S  = SW'(PAD_LX);
    localparam logic signed [SW-1:0] PADRX_S  = SW'(PAD_RX);
    localparam logic signed [SW-1:0] PADH_S   = SW'(PAD_H);
    localparam logic signed [SW-1:0] STEP_S   = SW'(PAD_STEP);
    localparam logic signed [SW-1:0] PADMAX_S = SW'(PAD_MAXT);

    localparam logic [3:0]    WIN_W   = 4'(WIN_SCORE);
    localparam logic [CW-1:0] SRV_END = CW'(SERVE_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_POINT,
        S_OVER
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]  x_q, x_nxt;
    logic [W-1:0]  y_q, y_nxt;
    logic [W-1:0]  lp_q, lp_nxt;
    logic [W-1:0]  rp_q, rp_nxt;
    logic          dx_q, dx_nxt;   // 1 = moving right
    logic          dy_q, dy_nxt;   // 1 = moving down
    logic [3:0]    sl_q, sl_nxt;
    logic [3:0]    sr_q, sr_nxt;
    logic [1:0]    lvl_q, lvl_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          over_q;

    logic signed [SW-1:0] xs, ys, lps, rps, spd, nx, ny;
    logic                 hit_l, hit_r;

    // Paddle step with clamping to the playfield; opposing buttons cancel.
    function automatic logic [W-1:0] pad_move(input logic [W-1:0] pos,
                                              input logic up, input logic dn);
        logic signed [SW-1:0] p;
        p = signed'(SW'(pos));
        if (up && !dn)
            p = p - STEP_S;
        else if (dn && !up)
            p = p + STEP_S;
        if (p < YMIN_S)
            p = YMIN_S;
        else if (p > PADMAX_S)
            p = PADMAX_S;
        return p[W-1:0];
    endfunction

    // Score increment saturating at the winning score.
    function automatic logic [3:0] sat_score(input logic [3:0] s);
        return (s >= WIN_W) ? WIN_W : s + 4'd1;
    endfunction

    // Speed level from total points, capped at 3.
    function automatic logic [1:0] calc_level(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] tot;
        logic [4:0] q;
        tot = {1'b0, a} + {1'b0, b};
        q   = tot / 5'(LEVEL_PTS);
        return (q > 5'd3) ? 2'd3 : q[1:0];
    endfunction

    // Match state register.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state, ball kinematics, scoring and paddle motion.
    always_comb begin
        state_nxt = state;
        x_nxt     = x_q;
        y_nxt     = y_q;
        lp_nxt    = lp_q;
        rp_nxt    = rp_q;
        dx_nxt    = dx_q;
        dy_nxt    = dy_q;
        sl_nxt    = sl_q;
        sr_nxt    = sr_q;
        lvl_nxt   = lvl_q;
        cnt_nxt   = cnt_q;

        xs    = signed'(SW'(x_q));
        ys    = signed'(SW'(y_q));
        lps   = signed'(SW'(lp_q));
        rps   = signed'(SW'(rp_q));
        spd   = signed'(SW'(lvl_q)) + ONE_S;
        nx    = dx_q ? xs + spd : xs - spd;
        ny    = dy_q ? ys + spd : ys - spd;
        // Paddle coverage uses the ball's and paddles' pre-tick positions.
        hit_l = (ys >= lps) && (ys < lps + PADH_S);
        hit_r = (ys >= rps) && (ys < rps + PADH_S);

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_SERVE;
                    cnt_nxt   = '0;
                    lvl_nxt   = calc_level(sl_q, sr_q);
                end
            end
            S_SERVE: begin
                if (bus.tick) begin
                    if (cnt_q == SRV_END) begin
                        state_nxt = S_PLAY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (bus.tick) begin
                    if (ny <= YMIN_S) begin
                        y_nxt  = Y_MIN_W;
                        dy_nxt = 1'b1;
                    end else if (ny >= YMAX_S) begin
                        y_nxt  = Y_MAX_W;
                        dy_nxt = 1'b0;
                    end else begin
                        y_nxt = ny[W-1:0];
                    end
                    // A miss leaves dx unchanged, so the next serve heads
                    // toward the player who just conceded.
                    if (!dx_q) begin
                        if (xs > PADLX_S && nx <= PADLX_S && hit_l) begin
                            x_nxt  = PAD_LX_W;
                            dx_nxt = 1'b1;
                        end else if (nx <= XMIN_S) begin
                            sr_nxt    = sat_score(sr_q);
                            state_nxt = S_POINT;
                            x_nxt     = XC_W;
                            y_nxt     = YC_W;
                        end else begin
                            x_nxt = nx[W-1:0];
                        end
                    end else begin
                        if (xs < PADRX_S && nx >= PADRX_S && hit_r) begin
                            x_nxt  = PAD_RX_W;
                            dx_nxt = 1'b0;
                        end else if (nx >= XMAX_S) begin
                            sl_nxt    = sat_score(sl_q);
                            state_nxt = S_POINT;
                            x_nxt     = XC_W;
                            y_nxt     = YC_W;
                        end else begin
                            x_nxt = nx[W-1:0];
                        end
                    end
                end
            end
            S_POINT: begin
                if (bus.tick) begin
                    if (sl_q == WIN_W || sr_q == WIN_W) begin
                        state_nxt = S_OVER;
                    end else begin
                        state_nxt = S_SERVE;
                        cnt_nxt   = '0;
                        lvl_nxt   = calc_level(sl_q, sr_q);
                    end
                end
            end
            S_OVER: begin
                if (bus.start) begin
                    state_nxt = S_IDLE;
                    sl_nxt    = '0;
                    sr_nxt    = '0;
                    lvl_nxt   = '0;
                    dx_nxt    = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (bus.tick && state != S_OVER) begin
            lp_nxt = pad_move(lp_q, bus.l_up, bus.l_dn);
            rp_nxt = pad_move(rp_q, bus.r_up, bus.r_dn);
        end
    end

    // Game datapath registers; a clear restores the whole power-on picture.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            x_q    <= XC_W;
            y_q    <= YC_W;
            lp_q   <= PAD_INIT_W;
            rp_q   <= PAD_INIT_W;
            dx_q   <= 1'b1;
            dy_q   <= 1'b1;
            sl_q   <= '0;
            sr_q   <= '0;
            lvl_q  <= '0;
            cnt_q  <= '0;
            over_q <= 1'b0;
        end else begin
            x_q    <= x_nxt;
            y_q    <= y_nxt;
            lp_q   <= lp_nxt;
            rp_q   <= rp_nxt;
            dx_q   <= dx_nxt;
            dy_q   <= dy_nxt;
            sl_q   <= sl_nxt;
            sr_q   <= sr_nxt;
            lvl_q  <= lvl_nxt;
            cnt_q  <= cnt_nxt;
            over_q <= (state_nxt == S_OVER);
        end
    end

    assign bus.ball_x    = x_q;
    assign bus.ball_y    = y_q;
    assign bus.l_pos     = lp_q;
    assign bus.r_pos     = rp_q;
    assign bus.score_l   = sl_q;
    assign bus.score_r   = sr_q;
    assign bus.level     = lvl_q;
    assign bus.game_over = over_q;

endmodule
